prbs9_gen: RTL and testbench

- Pattern source for the BER measurement path.
- Generates the PRBS9 sequence (x^9 + x^5 + 1, period 511) one bit per symbol strobe.
- Its outputs drive the BER checker's reference-bit and valid inputs, and the transmit path.
- Adds a programmable symbol-rate strobe, seed reload, zero-seed protection and a period-start marker so downstream sync windows can be aligned.

---
 rtl/prbs9_pkg.sv | 36 +++
 rtl/prbs9_lfsr.sv | 57 +++++
 rtl/prbs9_gen.sv | 137 +++++++++++++
 tb/tb_prbs9_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prbs9_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prbs9_pkg                                                  |
// | Description : Shared PRBS9 constants (x^9 + x^5 + 1), the per-clock      |
// |               action decode type and the LFSR step function. The BER     |
// |               checker imports PRBS9_PERIOD for its sync window.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package prbs9_pkg;

   localparam int PRBS9_LEN    = 9;
   localparam int PRBS9_PERIOD = 511;

   // Feedback taps as register bit positions: x^9 -> bit 8, x^5 -> bit 4.
   localparam int PRBS9_TAP_HI = 8;
   localparam int PRBS9_TAP_LO = 4;

   localparam logic [PRBS9_LEN-1:0] PRBS9_DEFAULT_SEED = 9'h1AA;

   typedef logic [PRBS9_LEN-1:0] prbs9_state_t;

   // What the generator does on a given clock, already priority-resolved.
   typedef enum logic [1:0] {
      PRBS9_ACT_LOAD   = 2'd0,
      PRBS9_ACT_HOLD   = 2'd1,
      PRBS9_ACT_COUNT  = 2'd2,
      PRBS9_ACT_STROBE = 2'd3
   } prbs9_action_t;

   // One Fibonacci step: shift left, feedback enters at bit 0.
   function automatic prbs9_state_t prbs9_step(input prbs9_state_t s);
      return {s[PRBS9_LEN-2:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/prbs9_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prbs9_lfsr                                                 |
// | Description : PRBS9 state register with step, seed load and zero-seed    |
// |               substitution. The all-zero state is unreachable because    |
// |               a zero seed is replaced by SEED on load.                   |
// | Ports       : clock       - rising-edge clock                            |
// |               i_reset     - asynchronous reset, active low               |
// |               i_advance   - step the register this clock                 |
// |               i_load      - load seed (wins over i_advance)              |
// |               i_seed      - seed value for i_load                        |
// |               o_msb       - current bit 8, the bit emitted on next step  |
// |               o_load_zero - i_load is active with an all-zero seed       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prbs9_lfsr
   import prbs9_pkg::*;
#(
   parameter logic [PRBS9_LEN-1:0] SEED = PRBS9_DEFAULT_SEED
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_advance,
   input  logic                 i_load,
   input  logic [PRBS9_LEN-1:0] i_seed,
   output logic                 o_msb,
   output logic                 o_load_zero
);

   prbs9_state_t lfsr_q;
   prbs9_state_t lfsr_d;
   logic         w_seed_zero;

   assign w_seed_zero = (i_seed == '0);

   always_comb begin
      lfsr_d = lfsr_q;
      if (i_load) begin
         lfsr_d = w_seed_zero ? SEED : i_seed;
      end else if (i_advance) begin
         lfsr_d = prbs9_step(lfsr_q);
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_msb       = lfsr_q[PRBS9_TAP_HI];
   assign o_load_zero = i_load & w_seed_zero;

endmodule
`default_nettype wire

// File: rtl/prbs9_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prbs9_gen                                                  |
// | Description : PRBS9 pattern source for the BER measurement path. Emits   |
// |               one registered bit every OS clocks, marks the first bit    |
// |               of each 511-bit period and flags zero-seed loads.          |
// | Ports       : clock          - rising-edge clock                         |
// |               i_reset        - asynchronous reset, active low            |
// |               i_enable       - 1 = run divider / LFSR, 0 = freeze        |
// |               i_load         - synchronous seed load                     |
// |               i_seed         - seed applied on i_load                    |
// |               o_bit          - current PRBS bit, stable between strobes  |
// |               o_valid        - one-clock pulse marking a new o_bit       |
// |               o_period_start - with o_valid on bit 1 of each period      |
// |               o_seed_err     - pulse when i_load sees i_seed == 0        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prbs9_gen
   import prbs9_pkg::*;
#(
   parameter int unsigned          OS   = 4,
   parameter logic [PRBS9_LEN-1:0] SEED = PRBS9_DEFAULT_SEED
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_load,
   input  logic [PRBS9_LEN-1:0] i_seed,
   output logic                 o_bit,
   output logic                 o_valid,
   output logic                 o_period_start,
   output logic                 o_seed_err
);

   // Divider needs at least one bit even when OS == 1 (it then stays at 0).
   localparam int DIV_W = (OS > 1) ? $clog2(OS) : 1;

   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(OS - 1);
   localparam logic [8:0]       C_IDX_LAST = 9'(PRBS9_PERIOD - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [8:0]       idx_q, idx_d;
   logic             bit_q, bit_d;
   logic             valid_q, valid_d;
   logic             period_start_q, period_start_d;
   logic             seed_err_q, seed_err_d;

   prbs9_action_t    w_action;
   logic             w_advance;
   logic             w_lfsr_msb;
   logic             w_load_zero;

   // Priority: load, then freeze, then divider count, then strobe. A load
   // coincident with a strobe therefore swallows that strobe.
   always_comb begin
      if (i_load) begin
         w_action = PRBS9_ACT_LOAD;
      end else if (!i_enable) begin
         w_action = PRBS9_ACT_HOLD;
      end else if (div_q != C_DIV_LAST) begin
         w_action = PRBS9_ACT_COUNT;
      end else begin
         w_action = PRBS9_ACT_STROBE;
      end
   end

   assign w_advance = (w_action == PRBS9_ACT_STROBE);

   prbs9_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_advance   (w_advance),
      .i_load      (i_load),
      .i_seed      (i_seed),
      .o_msb       (w_lfsr_msb),
      .o_load_zero (w_load_zero)
   );

   always_comb begin
      div_d          = div_q;
      idx_d          = idx_q;
      bit_d          = bit_q;
      valid_d        = 1'b0;
      period_start_d = 1'b0;
      seed_err_d     = 1'b0;

      unique case (w_action)
         PRBS9_ACT_LOAD: begin
            div_d      = '0;
            idx_d      = '0;
            seed_err_d = w_load_zero;
         end
         PRBS9_ACT_HOLD: begin
            // div is kept so the symbol phase resumes where it stopped.
         end
         PRBS9_ACT_COUNT: begin
            div_d = div_q + DIV_W'(1);
         end
         PRBS9_ACT_STROBE: begin
            div_d          = '0;
            bit_d          = w_lfsr_msb;
            valid_d        = 1'b1;
            period_start_d = (idx_q == '0);
            idx_d          = (idx_q == C_IDX_LAST) ? 9'd0 : idx_q + 9'd1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         div_q          <= '0;
         idx_q          <= '0;
         bit_q          <= 1'b0;
         valid_q        <= 1'b0;
         period_start_q <= 1'b0;
         seed_err_q     <= 1'b0;
      end else begin
         div_q          <= div_d;
         idx_q          <= idx_d;
         bit_q          <= bit_d;
         valid_q        <= valid_d;
         period_start_q <= period_start_d;
         seed_err_q     <= seed_err_d;
      end
   end

   assign o_bit          = bit_q;
   assign o_valid        = valid_q;
   assign o_period_start = period_start_q;
   assign o_seed_err     = seed_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs9_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prbs9_gen                                               |
// | Description : Directed bench for prbs9_gen. Instance A: SEED=1FF, OS=1   |
// |               (sequence, period, balance, load hold). Instance B:        |
// |               default SEED, OS=4 (strobe timing, freeze, zero-seed load, |
// |               asynchronous reset).                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prbs9_gen;

   logic       clock = 1'b0;
   always #5 clock = ~clock;

   logic       rst_a, en_a, ld_a;
   logic [8:0] seed_a;
   logic       bit_a, valid_a, ps_a, err_a;

   logic       rst_b, en_b, ld_b;
   logic [8:0] seed_b;
   logic       bit_b, valid_b, ps_b, err_b;

   prbs9_gen #(.OS(1), .SEED(9'h1FF)) u_dut_a (
      .clock          (clock),
      .i_reset        (rst_a),
      .i_enable       (en_a),
      .i_load         (ld_a),
      .i_seed         (seed_a),
      .o_bit          (bit_a),
      .o_valid        (valid_a),
      .o_period_start (ps_a),
      .o_seed_err     (err_a)
   );

   prbs9_gen #(.OS(4)) u_dut_b (
      .clock          (clock),
      .i_reset        (rst_b),
      .i_enable       (en_b),
      .i_load         (ld_b),
      .i_seed         (seed_b),
      .o_bit          (bit_b),
      .o_valid        (valid_b),
      .o_period_start (ps_b),
      .o_seed_err     (err_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference step from the polynomial: fb = bit8 ^ bit4 shifted in at bit 0.
   function automatic logic [8:0] step9(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Model state for instance B.
   logic [8:0] mb;
   logic       held_b;

   task automatic b_step(input string tag, input logic exp_valid, input logic exp_ps);
      tick();
      check({tag, "_valid"}, 32'(valid_b), 32'(exp_valid));
      check({tag, "_ps"}, 32'(ps_b), 32'(exp_ps));
      if (exp_valid) begin
         check({tag, "_bit"}, 32'(bit_b), 32'(mb[8]));
         held_b = mb[8];
         mb     = step9(mb);
      end else begin
         check({tag, "_hold"}, 32'(bit_b), 32'(held_b));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic       bits_a [1:1022];
   logic [8:0] ma;

   initial begin
      int errs, vgaps, ps_bad, ps_good, ones1, ones2, rep_bad;

      rst_a = 1'b0; en_a = 1'b0; ld_a = 1'b0; seed_a = 9'h000;
      rst_b = 1'b0; en_b = 1'b0; ld_b = 1'b0; seed_b = 9'h000;
      #2;
      check("a_reset_outputs", 32'({bit_a, valid_a, ps_a, err_a}), 32'(0));
      check("b_reset_outputs", 32'({bit_b, valid_b, ps_b, err_b}), 32'(0));
      repeat (2) tick();

      // ---------------- Instance A: OS=1, SEED=1FF ----------------
      rst_a = 1'b1; en_a = 1'b1;
      ma = 9'h1FF;
      errs = 0; vgaps = 0; ps_bad = 0; ps_good = 0; ones1 = 0; ones2 = 0; rep_bad = 0;
      for (int s = 1; s <= 1022; s++) begin
         tick();
         if (valid_a !== 1'b1) vgaps++;
         if (bit_a !== ma[8]) errs++;
         if (s <= 10) check($sformatf("a_first_bit%0d", s), 32'(bit_a), (s == 10) ? 32'(0) : 32'(1));
         bits_a[s] = bit_a;
         if (ps_a === 1'b1) begin
            if (s == 1 || s == 512) ps_good++;
            else ps_bad++;
         end
         if (bit_a === 1'b1) begin
            if (s <= 511) ones1++;
            else ones2++;
         end
         ma = step9(ma);
      end
      for (int k = 0; k < 511; k++) if (bits_a[512 + k] !== bits_a[1 + k]) rep_bad++;
      check("a_valid_every_clock", 32'(vgaps), 32'(0));
      check("a_seq_vs_model", 32'(errs), 32'(0));
      check("a_period_start_hits", 32'(ps_good), 32'(2));
      check("a_period_start_extra", 32'(ps_bad), 32'(0));
      check("a_period_repeat", 32'(rep_bad), 32'(0));
      check("a_ones_period1", 32'(ones1), 32'(256));
      check("a_ones_period2", 32'(ones2), 32'(256));

      // Held load: no strobes while i_load stays high.
      ld_a = 1'b1; seed_a = 9'h0F0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("a_load_held_valid", 32'(valid_a), 32'(0));
         check("a_load_nonzero_err", 32'(err_a), 32'(0));
      end
      ld_a = 1'b0;
      // 0F0 emits 0 first; next state 1E1 emits 1.
      tick();
      check("a_after_load_valid", 32'(valid_a), 32'(1));
      check("a_after_load_ps", 32'(ps_a), 32'(1));
      check("a_after_load_bit1", 32'(bit_a), 32'(0));
      tick();
      check("a_after_load_bit2", 32'(bit_a), 32'(1));
      check("a_after_load_ps2", 32'(ps_a), 32'(0));
      en_a = 1'b0;
      tick();
      check("a_disabled_valid", 32'(valid_a), 32'(0));

      // ---------------- Instance B: OS=4, SEED=1AA ----------------
      rst_b = 1'b1; en_b = 1'b1;
      mb = 9'h1AA; held_b = 1'b0;
      for (int e = 1; e <= 12; e++) b_step("b_run", (e % 4) == 0, e == 4);
      // Two more enabled edges leave the divider at 2, then freeze.
      b_step("b_pre_gap", 1'b0, 1'b0);
      b_step("b_pre_gap", 1'b0, 1'b0);
      en_b = 1'b0;
      for (int i = 0; i < 10; i++) b_step("b_gap", 1'b0, 1'b0);
      en_b = 1'b1;
      b_step("b_resume1", 1'b0, 1'b0);
      b_step("b_resume2", 1'b1, 1'b0);

      // Bring divider to OS-1 so the load lands on a strobe edge.
      for (int i = 0; i < 3; i++) b_step("b_pre_load", 1'b0, 1'b0);
      ld_b = 1'b1; seed_b = 9'h000;
      tick();
      check("b_zero_load_err", 32'(err_b), 32'(1));
      check("b_zero_load_valid", 32'(valid_b), 32'(0));
      check("b_zero_load_ps", 32'(ps_b), 32'(0));
      check("b_zero_load_bit_hold", 32'(bit_b), 32'(held_b));
      ld_b = 1'b0;
      mb = 9'h1AA;
      for (int e = 1; e <= 8; e++) begin
         b_step("b_after_zero_load", (e % 4) == 0, e == 4);
         if (e == 1) check("b_seed_err_one_clock", 32'(err_b), 32'(0));
      end

      // Last strobe emitted bit 2 of the 1AA sequence, which is 1.
      check("b_pre_async_valid", 32'(valid_b), 32'(1));
      check("b_pre_async_bit", 32'(bit_b), 32'(1));
      #2;
      rst_b = 1'b0;
      #1;
      check("b_async_reset_outputs", 32'({bit_b, valid_b, ps_b, err_b}), 32'(0));
      tick();
      rst_b = 1'b1;
      mb = 9'h1AA; held_b = 1'b0;
      for (int e = 1; e <= 8; e++) b_step("b_after_reset", (e % 4) == 0, e == 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
